openhmc_axis_protocol_monitor: RTL and testbench
================================================

Name: openhmc_axis_protocol_monitor

Overview:
Synthesizable, multi-channel AXI4-Stream protocol monitor for the openHMC controller. Taps the TX (user-to-controller) and RX (controller-to-user) AXI streams without driving them. Per channel, it detects handshake-stability violations and stall timeouts, and keeps sticky error flags plus beat, error and maximum-stall statistics. Statistics are read out through a registered channel-select port for RF or debug access.

Parameters:
NUM_CH, 2, number of monitored AXI-Stream channels (1..8)
CH_SEL_W, 1, width of ch_sel; must be >= clog2(NUM_CH), minimum 1
DWIDTH, 512, TDATA width per channel (FPW*128)
UWIDTH, 64, TUSER width per channel (FPW*16)
STALL_TIMEOUT_LOG, 10, a stall timeout fires after 2^STALL_TIMEOUT_LOG consecutive stalled cycles
CNT_W, 32, width of the beat and error counters
STALL_W, 16, width of the maximum-stall register

Ports:
clk_hmc  in  1  clock, single clock domain
res_n_hmc  in  1  reset, synchronous, active-low
mon_tvalid  in  NUM_CH  TVALID per channel
mon_tready  in  NUM_CH  TREADY per channel
mon_tdata  in  NUM_CH*DWIDTH  TDATA; channel c occupies bits [c*DWIDTH +: DWIDTH]
mon_tuser  in  NUM_CH*UWIDTH  TUSER; channel c occupies bits [c*UWIDTH +: UWIDTH]
clear  in  1  synchronous clear of flags and statistics, all channels
ch_sel  in  CH_SEL_W  channel selected for statistics readout
err_flags  out  NUM_CH*4  sticky flags per channel, bit order {TIMEOUT, USER_CHG, DATA_CHG, VALID_DROP}
err_pulse  out  1  one-cycle pulse on any newly detected error
sel_beat_cnt  out  CNT_W  beat count of the selected channel
sel_err_cnt  out  CNT_W  error count of the selected channel
sel_max_stall  out  STALL_W  longest stall seen on the selected channel

Behaviour:
- Reset, when res_n_hmc=0 at a clock edge:
  - all outputs are 0
  - every channel FSM goes to IDLE
  - stall counters and snapshots are 0
- Per-channel FSM states: IDLE, STALLED, TIMEOUT.
- IDLE:
  - valid&ready: beat++, stay in IDLE.
  - valid&!ready: go to STALLED; snapshot TDATA/TUSER; stall_cnt=1.
  - !valid: stay in IDLE.
- STALLED or TIMEOUT, in any cycle with valid=1:
  - compare TDATA with the snapshot; a mismatch raises DATA_CHG.
  - compare TUSER with the snapshot; a mismatch raises USER_CHG.
  - the snapshot is not updated; the first stalled beat is the reference until the handshake.
- STALLED or TIMEOUT, transitions:
  - valid&ready: beat++, update max_stall, go to IDLE.
  - !valid: raise VALID_DROP, update max_stall, go to IDLE.
  - valid&!ready: stall_cnt++, saturating at STALL_W all-ones.
- STALLED to TIMEOUT: when stall_cnt reaches 2^STALL_TIMEOUT_LOG, raise TIMEOUT once and go to TIMEOUT. TIMEOUT is not re-raised while the channel stays stalled.
- Detection latency: an error detected in cycle N sets its err_flags bit and err_pulse at edge N+1. err_pulse is high for exactly one cycle per detecting cycle.
- err_cnt: +1 per cycle in which any error bit of that channel is raised (not +1 per bit). Saturates at all-ones.
- beat_cnt: wraps modulo 2^CNT_W.
- max_stall: becomes max(max_stall, stall_cnt) at stall end, saturating.
- clear=1:
  - zeroes all err_flags, beat_cnt, err_cnt and max_stall.
  - FSM state and snapshots are untouched.
  - events detected in the same cycle are applied after the clear, so a new error is still flagged and counted as 1.
- Readout: sel_* outputs are registered, 1-cycle latency from ch_sel and from counter updates. ch_sel >= NUM_CH reads all zeros.
- Channels are fully independent. Simultaneous errors on several channels produce one err_pulse.

Optional Feature:
Macro: AXIS_MON_DATA_CHECK_EN.
- Defined: a DWIDTH-bit TDATA snapshot is kept per channel and DATA_CHG is checked as above.
- Undefined: no TDATA snapshot or comparator is built; the DATA_CHG flag is tied to 0 and never increments err_cnt. mon_tdata is left unused, which saves NUM_CH*DWIDTH flops. All other checks are unchanged.

Test Plan:
1. Reset, then ch0 valid&ready for 5 cycles, ch_sel=0 -> sel_beat_cnt=5, sel_err_cnt=0, err_flags=0.
2. ch1 valid with ready=0 for 3 cycles holding TUSER=0xAA, then ready=1 -> beat_cnt=1, sel_max_stall=3, no flags.
3. ch0 stalled with TUSER=0x01, next cycle TUSER=0x02 and TDATA changed (macro defined) -> err_flags[3:0]=4'b0110, err_pulse high 1 cycle, err_cnt=1. With the macro undefined -> 4'b0100.
4. ch1 valid=1 with ready=0 for 1 cycle, then valid=0 -> err_flags[7:4]=4'b0001, FSM returns to IDLE, next clean beat counted.
5. STALL_TIMEOUT_LOG=4, ch0 stalled for 20 cycles -> TIMEOUT set exactly once at stall cycle 16, err_cnt=1, max_stall=20 after the handshake.
6. clear asserted in the same cycle as a VALID_DROP on ch0 -> after the edge, beat_cnt=0 and err_cnt=1 with only VALID_DROP set. Reset mid-stall -> FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/openhmc_axis_protocol_monitor.sv
// Multi-channel AXI4-Stream protocol monitor: stall stability, valid drops, stall timeouts, statistics.
// Optional macro AXIS_MON_DATA_CHECK_EN builds the TDATA snapshot and DATA_CHG comparator.
module openhmc_axis_protocol_monitor #(
   parameter int NUM_CH            = 2,
   parameter int CH_SEL_W          = 1,
   parameter int DWIDTH            = 512,
   parameter int UWIDTH            = 64,
   parameter int STALL_TIMEOUT_LOG = 10,
   parameter int CNT_W             = 32,
   parameter int STALL_W           = 16
) (
   input  logic                     clk_hmc,
   input  logic                     res_n_hmc,
   input  logic [NUM_CH-1:0]        mon_tvalid,
   input  logic [NUM_CH-1:0]        mon_tready,
   input  logic [NUM_CH*DWIDTH-1:0] mon_tdata,
   input  logic [NUM_CH*UWIDTH-1:0] mon_tuser,
   input  logic                     clear,
   input  logic [CH_SEL_W-1:0]      ch_sel,
   output logic [NUM_CH*4-1:0]      err_flags,
   output logic                     err_pulse,
   output logic [CNT_W-1:0]         sel_beat_cnt,
   output logic [CNT_W-1:0]         sel_err_cnt,
   output logic [STALL_W-1:0]       sel_max_stall
);

   typedef enum logic [1:0] {IDLE, STALLED, TIMEOUT} state_t;

   // Zero when the threshold cannot be reached by a saturating STALL_W counter.
   localparam logic [STALL_W:0] THRESH =
      (STALL_TIMEOUT_LOG < STALL_W) ? ((STALL_W+1)'(1) << STALL_TIMEOUT_LOG) : '0;

   logic [NUM_CH-1:0]         det_bus;
   logic [NUM_CH*CNT_W-1:0]   beat_bus;
   logic [NUM_CH*CNT_W-1:0]   err_bus;
   logic [NUM_CH*STALL_W-1:0] max_bus;

`ifndef AXIS_MON_DATA_CHECK_EN
   logic unused_tdata;
   assign unused_tdata = ^mon_tdata;
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t             state_reg, state_next;
      logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next, stall_cnt_inc;
      logic [STALL_W-1:0] max_stall_reg, max_stall_next, max_base;
      logic [UWIDTH-1:0]  snap_user_reg;
      logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next, beat_base;
      logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next, err_base;
      logic [3:0]         flags_reg, flags_next, raise;
      logic               valid, ready, stalled, beat_inc, stall_end, data_chg;
      logic [UWIDTH-1:0]  user;

      assign valid   = mon_tvalid[gi];
      assign ready   = mon_tready[gi];
      assign user    = mon_tuser[gi*UWIDTH +: UWIDTH];
      assign stalled = (state_reg != IDLE);

`ifdef AXIS_MON_DATA_CHECK_EN
      logic [DWIDTH-1:0] data, snap_data_reg;
      assign data     = mon_tdata[gi*DWIDTH +: DWIDTH];
      assign data_chg = stalled && valid && (data != snap_data_reg);

      always_ff @(posedge clk_hmc) begin
         if (!res_n_hmc)
            snap_data_reg <= '0;
         else if (state_reg == IDLE && valid && !ready)
            snap_data_reg <= data;
      end
`else
      assign data_chg = 1'b0;
`endif

      always_comb begin
         state_next     = state_reg;
         stall_cnt_next = stall_cnt_reg;
         stall_cnt_inc  = (stall_cnt_reg == '1) ? stall_cnt_reg : stall_cnt_reg + 1'b1;
         beat_inc       = 1'b0;
         stall_end      = 1'b0;
         raise          = 4'b0000;
         raise[1]       = data_chg;
         raise[2]       = stalled && valid && (user != snap_user_reg);
         case (state_reg)
            IDLE: begin
               if (valid && ready) begin
                  beat_inc = 1'b1;
               end else if (valid) begin
                  state_next     = STALLED;
                  stall_cnt_next = STALL_W'(1);
               end
            end
            default: begin
               if (valid && ready) begin
                  beat_inc       = 1'b1;
                  stall_end      = 1'b1;
                  state_next     = IDLE;
                  stall_cnt_next = '0;
               end else if (!valid) begin
                  raise[0]       = 1'b1;
                  stall_end      = 1'b1;
                  state_next     = IDLE;
                  stall_cnt_next = '0;
               end else begin
                  stall_cnt_next = stall_cnt_inc;
               end
            end
         endcase
         // TIMEOUT state is sticky until the stall ends, so the flag fires once per stall.
         if (state_next == STALLED && {1'b0, stall_cnt_next} == THRESH) begin
            raise[3]   = 1'b1;
            state_next = TIMEOUT;
         end

         beat_base      = clear ? '0 : beat_cnt_reg;
         err_base       = clear ? '0 : err_cnt_reg;
         max_base       = clear ? '0 : max_stall_reg;
         beat_cnt_next  = beat_base + CNT_W'(beat_inc);
         err_cnt_next   = ((|raise) && (err_base != '1)) ? err_base + 1'b1 : err_base;
         flags_next     = (clear ? 4'b0000 : flags_reg) | raise;
         max_stall_next = (stall_end && stall_cnt_reg > max_base) ? stall_cnt_reg : max_base;
      end

      always_ff @(posedge clk_hmc) begin
         if (!res_n_hmc) begin
            state_reg     <= IDLE;
            stall_cnt_reg <= '0;
            snap_user_reg <= '0;
            beat_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            max_stall_reg <= '0;
            flags_reg     <= '0;
         end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            if (state_reg == IDLE && valid && !ready)
               snap_user_reg <= user;
            beat_cnt_reg  <= beat_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            max_stall_reg <= max_stall_next;
            flags_reg     <= flags_next;
         end
      end

      assign det_bus[gi]                       = |raise;
      assign err_flags[gi*4 +: 4]              = flags_reg;
      assign beat_bus[gi*CNT_W +: CNT_W]       = beat_cnt_reg;
      assign err_bus[gi*CNT_W +: CNT_W]        = err_cnt_reg;
      assign max_bus[gi*STALL_W +: STALL_W]    = max_stall_reg;
   end

   logic [CNT_W-1:0]   sel_beat_next, sel_err_next;
   logic [STALL_W-1:0] sel_max_next;

   always_comb begin
      sel_beat_next = '0;
      sel_err_next  = '0;
      sel_max_next  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel == CH_SEL_W'(c)) begin
            sel_beat_next = beat_bus[c*CNT_W +: CNT_W];
            sel_err_next  = err_bus[c*CNT_W +: CNT_W];
            sel_max_next  = max_bus[c*STALL_W +: STALL_W];
         end
      end
   end

   always_ff @(posedge clk_hmc) begin
      if (!res_n_hmc) begin
         err_pulse     <= 1'b0;
         sel_beat_cnt  <= '0;
         sel_err_cnt   <= '0;
         sel_max_stall <= '0;
      end else begin
         err_pulse     <= |det_bus;
         sel_beat_cnt  <= sel_beat_next;
         sel_err_cnt   <= sel_err_next;
         sel_max_stall <= sel_max_next;
      end
   end

endmodule

// File: tb/tb_openhmc_axis_protocol_monitor.sv
// Directed scoreboard bench for openhmc_axis_protocol_monitor (2 channels, timeout after 16 stalled cycles).
module tb_openhmc_axis_protocol_monitor;

   localparam int NUM_CH = 2;
   localparam int CH_SEL_W = 2;
   localparam int DWIDTH = 32;
   localparam int UWIDTH = 8;
   localparam int CNT_W = 32;
   localparam int STALL_W = 16;

`ifdef AXIS_MON_DATA_CHECK_EN
   localparam logic [3:0] CH0_CHG = 4'b0110;
`else
   localparam logic [3:0] CH0_CHG = 4'b0100;
`endif

   logic clk = 1'b0;
   logic res_n = 1'b0;
   logic clear = 1'b0;
   logic [CH_SEL_W-1:0] ch_sel = '0;
   logic [NUM_CH-1:0] tv = '0, tr = '0;
   logic [NUM_CH*DWIDTH-1:0] td = '0;
   logic [NUM_CH*UWIDTH-1:0] tu = '0;
   logic [NUM_CH*4-1:0] err_flags;
   logic err_pulse;
   logic [CNT_W-1:0] sel_beat_cnt, sel_err_cnt;
   logic [STALL_W-1:0] sel_max_stall;

   always #5 clk = ~clk;

   openhmc_axis_protocol_monitor #(
      .NUM_CH(NUM_CH), .CH_SEL_W(CH_SEL_W), .DWIDTH(DWIDTH), .UWIDTH(UWIDTH),
      .STALL_TIMEOUT_LOG(4), .CNT_W(CNT_W), .STALL_W(STALL_W)
   ) dut (
      .clk_hmc(clk), .res_n_hmc(res_n),
      .mon_tvalid(tv), .mon_tready(tr), .mon_tdata(td), .mon_tuser(tu),
      .clear(clear), .ch_sel(ch_sel),
      .err_flags(err_flags), .err_pulse(err_pulse),
      .sel_beat_cnt(sel_beat_cnt), .sel_err_cnt(sel_err_cnt), .sel_max_stall(sel_max_stall)
   );

   typedef struct {
      string       tag;
      int          kind;
      logic [63:0] val;
   } exp_t;

   exp_t sbq[$];
   int compared = 0;
   int mismatched = 0;

   function automatic logic [63:0] obs(input int kind);
      case (kind)
         0:       return {56'b0, err_flags};
         1:       return {63'b0, err_pulse};
         2:       return {32'b0, sel_beat_cnt};
         3:       return {32'b0, sel_err_cnt};
         default: return {48'b0, sel_max_stall};
      endcase
   endfunction

   task automatic expect_val(input string tag, input int kind, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.kind = kind;
      e.val = val;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [63:0] o;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obs(e.kind);
         compared++;
         assert (o === e.val) begin
            $display("check %s observed=%0h expected=%0h ok", e.tag, o, e.val);
         end else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int ch, input bit vv, input bit rr, input logic [7:0] uu,
                        input logic [31:0] dd);
      tv[ch] = vv;
      tr[ch] = rr;
      tu[ch*UWIDTH +: UWIDTH] = uu;
      td[ch*DWIDTH +: DWIDTH] = dd;
   endtask

   task automatic idle_all();
      tv = '0;
      tr = '0;
   endtask

   task automatic read(input int ch);
      ch_sel = CH_SEL_W'(ch);
      tick(2);
   endtask

   task automatic expect_stats(input string tag, input logic [31:0] beat, input logic [31:0] errs,
                               input logic [15:0] mx);
      expect_val({tag, "_beat"}, 2, {32'b0, beat});
      expect_val({tag, "_err"}, 3, {32'b0, errs});
      expect_val({tag, "_max"}, 4, {48'b0, mx});
   endtask

   initial begin
      // Reset
      tick(3);
      expect_val("rst_flags", 0, 64'h0);
      expect_val("rst_pulse", 1, 64'h0);
      expect_stats("rst", 0, 0, 0);
      drain();
      res_n = 1'b1;

      // 1: five clean beats on ch0
      drive(0, 1, 1, 8'h00, 32'h0);
      tick(5);
      idle_all();
      read(0);
      expect_stats("t1", 5, 0, 0);
      expect_val("t1_flags", 0, 64'h0);
      drain();
      read(2);
      expect_stats("t1_sel_oob", 0, 0, 0);
      drain();

      // 2: ch1 stalls 3 cycles then handshakes
      drive(1, 1, 0, 8'hAA, 32'h5555);
      tick(3);
      drive(1, 1, 1, 8'hAA, 32'h5555);
      tick(1);
      idle_all();
      read(1);
      expect_stats("t2", 1, 0, 3);
      expect_val("t2_flags", 0, 64'h0);
      drain();

      // 3: TUSER/TDATA change during ch0 stall
      drive(0, 1, 0, 8'h01, 32'h1111);
      tick(1);
      drive(0, 1, 0, 8'h02, 32'h2222);
      tick(1);
      expect_val("t3_flags", 0, {56'b0, 4'b0000, CH0_CHG});
      expect_val("t3_pulse", 1, 64'h1);
      drain();
      drive(0, 1, 1, 8'h01, 32'h1111);
      tick(1);
      expect_val("t3_pulse_gone", 1, 64'h0);
      drain();
      idle_all();
      read(0);
      expect_stats("t3", 6, 1, 2);
      drain();

      // 4: ch1 valid drop mid-stall, then a clean beat
      drive(1, 1, 0, 8'hAA, 32'h0);
      tick(1);
      drive(1, 0, 0, 8'hAA, 32'h0);
      tick(1);
      expect_val("t4_flags", 0, {56'b0, 4'b0001, CH0_CHG});
      expect_val("t4_pulse", 1, 64'h1);
      drain();
      drive(1, 1, 1, 8'hAA, 32'h0);
      tick(1);
      expect_val("t4_pulse_gone", 1, 64'h0);
      drain();
      idle_all();
      read(1);
      expect_stats("t4", 2, 1, 3);
      drain();

      // 5: clear, then a 20-cycle ch0 stall with timeout at cycle 16
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      expect_val("t5_clear_flags", 0, 64'h0);
      drain();
      drive(0, 1, 0, 8'h05, 32'h7777);
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         expect_val($sformatf("t5_pulse_%0d", k), 1, (k == 16) ? 64'h1 : 64'h0);
         expect_val($sformatf("t5_flags_%0d", k), 0, (k >= 16) ? 64'h8 : 64'h0);
         drain();
      end
      drive(0, 1, 1, 8'h05, 32'h7777);
      tick(1);
      idle_all();
      read(0);
      expect_stats("t5", 1, 1, 20);
      expect_val("t5_flags", 0, 64'h8);
      drain();

      // 6: clear coinciding with a ch0 valid drop
      drive(0, 1, 0, 8'h09, 32'h0);
      tick(1);
      drive(0, 0, 0, 8'h09, 32'h0);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      expect_val("t6_flags", 0, 64'h1);
      drain();
      read(0);
      expect_stats("t6", 0, 1, 1);
      drain();

      // 6b: reset while ch1 is stalled
      drive(1, 1, 0, 8'h33, 32'h0);
      tick(3);
      res_n = 1'b0;
      tick(1);
      expect_val("t6r_flags", 0, 64'h0);
      expect_val("t6r_pulse", 1, 64'h0);
      expect_stats("t6r", 0, 0, 0);
      drain();
      res_n = 1'b1;
      drive(1, 0, 0, 8'h33, 32'h0);
      tick(1);
      expect_val("t6r_no_drop_flags", 0, 64'h0);
      expect_val("t6r_no_drop_pulse", 1, 64'h0);
      drain();
      drive(1, 1, 1, 8'h33, 32'h0);
      tick(1);
      idle_all();
      read(1);
      expect_stats("t6r_after", 1, 0, 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
